// File: rtl/proj_pkg.sv
// Project-wide constants shared by the feature-map datapath blocks.
package proj_pkg;
  localparam int FM_BUFFER_SIZE = 8;  // FM buffer address width in bits
endpackage

// File: rtl/proj_fm_addr_gen_if.sv
// Address stream from proj_fm_addr_gen to the FM buffer read port (valid/ready).
interface proj_fm_addr_gen_if #(
  parameter int ADDR_W = proj_pkg::FM_BUFFER_SIZE
);
  logic              out_valid;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last_in_pass;
  logic              out_last;
  logic              in_ready;

  modport master (output out_valid, out_addr, out_last_in_pass, out_last, input in_ready);
  modport slave  (input out_valid, out_addr, out_last_in_pass, out_last, output in_ready);
endinterface

// File: rtl/proj_fm_addr_gen.sv
// Multi-pass FM buffer address generator: base/len/passes runs on a registered valid/ready stream.
// Optional macro PROJ_FM_ADDR_GEN_STRIDE_EN adds a programmable address stride (default stride 1).
module proj_fm_addr_gen #(
  parameter int ADDR_W = proj_pkg::FM_BUFFER_SIZE,
  parameter int PASS_W = 4
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_start,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] in_len,
  input  logic [PASS_W-1:0] in_passes,
`ifdef PROJ_FM_ADDR_GEN_STRIDE_EN
  input  logic [ADDR_W-1:0] in_stride,
`endif
  input  logic              in_abort,
  proj_fm_addr_gen_if.master fm,
  output logic              out_busy,
  output logic              out_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ADDR_W-1:0] L_ONE = ADDR_W'(1);
  localparam logic [PASS_W-1:0] P_ONE = PASS_W'(1);

  logic [1:0]        r_state;
  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic              r_lip;
  logic              r_last;
  logic              r_busy;
  logic              r_done;

  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_len_m1;
  logic [PASS_W-1:0] r_last_pass;
  logic [ADDR_W-1:0] r_offset;
  logic [PASS_W-1:0] r_pass;

  logic              w_accept;
  logic              w_xfer;
  logic [PASS_W-1:0] w_passes_eff;
  logic [ADDR_W-1:0] w_stride;
  logic [ADDR_W-1:0] w_off_nxt;
  logic [PASS_W-1:0] w_pass_nxt;
  logic              w_start_lip;
  logic              w_adv_lip;
  logic              w_roll_lip;

`ifdef PROJ_FM_ADDR_GEN_STRIDE_EN
  logic [ADDR_W-1:0] r_stride;
  assign w_stride = r_stride;
`else
  assign w_stride = L_ONE;
`endif

  assign w_accept     = (r_state == S_IDLE) && in_start;
  assign w_xfer       = r_valid && fm.in_ready;
  assign w_passes_eff = (in_passes == '0) ? P_ONE : in_passes;
  assign w_off_nxt    = r_offset + L_ONE;
  assign w_pass_nxt   = r_pass + P_ONE;
  // Flag look-ahead so last-in-pass/last are registered alongside the address they qualify.
  assign w_start_lip  = (in_len == L_ONE);
  assign w_adv_lip    = (w_off_nxt == r_len_m1);
  assign w_roll_lip   = (r_len_m1 == '0);

  // NOTE: run parameters and counters need no reset; they are always loaded on an accepted start
  // before anything reads them.
  always_ff @(posedge in_clk) begin
    if (w_accept) begin
      r_base      <= in_base;
      r_len_m1    <= in_len - L_ONE;
      r_last_pass <= w_passes_eff - P_ONE;
`ifdef PROJ_FM_ADDR_GEN_STRIDE_EN
      r_stride    <= in_stride;
`endif
      r_offset    <= '0;
      r_pass      <= '0;
    end else if (w_xfer) begin
      if (r_lip) begin
        r_offset <= '0;
        r_pass   <= w_pass_nxt;
      end else begin
        r_offset <= w_off_nxt;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_lip   <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (in_start) begin
            if (in_len != '0) begin
              r_state <= S_RUN;
              r_valid <= 1'b1;
              r_busy  <= 1'b1;
              r_addr  <= in_base;
              r_lip   <= w_start_lip;
              r_last  <= w_start_lip && (w_passes_eff == P_ONE);
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (in_abort) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_lip   <= 1'b0;
            r_last  <= 1'b0;
          end else if (w_xfer) begin
            if (r_last) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_lip   <= 1'b0;
              r_last  <= 1'b0;
            end else if (r_lip) begin
              // New pass: the address accumulator restarts from base.
              r_addr <= r_base;
              r_lip  <= w_roll_lip;
              r_last <= w_roll_lip && (w_pass_nxt == r_last_pass);
            end else begin
              r_addr <= r_addr + w_stride;
              r_lip  <= w_adv_lip;
              r_last <= w_adv_lip && (r_pass == r_last_pass);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_lip   <= 1'b0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

  assign fm.out_valid        = r_valid;
  assign fm.out_addr         = r_addr;
  assign fm.out_last_in_pass = r_lip;
  assign fm.out_last         = r_last;
  assign out_busy            = r_busy;
  assign out_done            = r_done;

endmodule
